// File: rtl/esfa_program_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// esfa_seq_pkg -- shared instruction layout, ESFA operand types, FSM states. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package esfa_seq_pkg;

  localparam int c_INSTR_W      = 56;
  localparam int c_ESFA_DATA_W  = 8;

  localparam int c_BIT_WRITE    = 0;
  localparam int c_LSB_INDEX    = 8;
  localparam int c_LSB_VALUE    = 16;
  localparam int c_LSB_META     = 24;
  localparam int c_BIT_IS_META  = 32;
  localparam int c_LSB_SEL      = 40;
  localparam int c_BIT_ASSERT   = 48;
  localparam int c_BIT_HALT     = 49;

  typedef logic [c_INSTR_W-1:0]     instr_word_t;
  typedef logic [c_ESFA_DATA_W-1:0] esfa_data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic       write;
    esfa_data_t index;
    esfa_data_t value;
    esfa_data_t metadata;
    logic       is_metadata;
    esfa_data_t selector;
    logic       is_assert;
    logic       halt;
  } instr_t;

endpackage

`default_nettype wire

// File: rtl/esfa_program_sequencer_if.sv
// ----------------------------------------------------------------------------
// esfa_program_sequencer_if -- ROM fetch and ESFA write/query bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface esfa_program_sequencer_if
  import esfa_seq_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  instr_word_t       rom_data;
  logic              esfa_will_write;
  esfa_data_t        esfa_new_index;
  esfa_data_t        esfa_new_value;
  esfa_data_t        esfa_metadata;
  logic              esfa_is_metadata;
  esfa_data_t        esfa_selector;
  logic              esfa_result_bool;
  esfa_data_t        esfa_result_value;

  modport master (
    output rom_addr,
    input  rom_data,
    output esfa_will_write, esfa_new_index, esfa_new_value,
    output esfa_metadata, esfa_is_metadata, esfa_selector,
    input  esfa_result_bool, esfa_result_value
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  esfa_will_write, esfa_new_index, esfa_new_value,
    input  esfa_metadata, esfa_is_metadata, esfa_selector,
    output esfa_result_bool, esfa_result_value
  );
endinterface

`default_nettype wire

// File: rtl/esfa_instr_decode.sv
// ----------------------------------------------------------------------------
// esfa_instr_decode -- combinational field extraction from the instruction register. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module esfa_instr_decode
  import esfa_seq_pkg::*;
(
  input  instr_word_t ir_i,
  output instr_t      instr_o
);

  logic w_unused_reserved;

  always_comb begin
    instr_o             = '0;
    instr_o.write       = ir_i[c_BIT_WRITE];
    instr_o.index       = ir_i[c_LSB_INDEX +: c_ESFA_DATA_W];
    instr_o.value       = ir_i[c_LSB_VALUE +: c_ESFA_DATA_W];
    instr_o.metadata    = ir_i[c_LSB_META  +: c_ESFA_DATA_W];
    instr_o.is_metadata = ir_i[c_BIT_IS_META];
    instr_o.selector    = ir_i[c_LSB_SEL   +: c_ESFA_DATA_W];
    instr_o.is_assert   = ir_i[c_BIT_ASSERT];
    instr_o.halt        = ir_i[c_BIT_HALT];
  end

  // Reserved bits are deliberately ignored.
  assign w_unused_reserved = ^{ir_i[7:1], ir_i[39:33], ir_i[55:50]};

endmodule

`default_nettype wire

// File: rtl/esfa_program_sequencer.sv
// ----------------------------------------------------------------------------
// esfa_program_sequencer -- fetches, decodes and runs ESFA test programs from ROM. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module esfa_program_sequencer
  import esfa_seq_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255,
  parameter int ESFA_LAT  = 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  esfa_program_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [ADDR_W:0]      instr_count
);

  localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(LAST_ADDR);
  localparam logic [2:0]        c_WAIT_INIT = 3'((ESFA_LAT > 1) ? ESFA_LAT - 2 : 0);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  instr_word_t       ir_q;
  logic              will_write_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [ADDR_W:0]   instr_count_q;
  logic [2:0]        wait_cnt_q;

  instr_t w_instr;
  logic   w_match;
  logic   w_complete;
  logic   w_finish;

  esfa_instr_decode u_decode (
    .ir_i    (ir_q),
    .instr_o (w_instr)
  );

  assign w_match    = (bus.esfa_result_bool == w_instr.is_metadata) &&
                      (bus.esfa_result_value == w_instr.metadata);
  assign w_complete = ((state_q == ST_EXEC) && !w_instr.is_assert) ||
                      ((state_q == ST_CHECK) && w_match);
  assign w_finish   = w_instr.halt || (pc_q == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      will_write_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_addr_q   <= '0;
      instr_count_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      will_write_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pc_q          <= '0;
            instr_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_addr_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          ir_q         <= bus.rom_data;
          // Asserts never write, even with the write bit set.
          will_write_q <= bus.rom_data[c_BIT_WRITE] & ~bus.rom_data[c_BIT_ASSERT];
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_instr.is_assert) begin
            if (ESFA_LAT > 1) begin
              wait_cnt_q <= c_WAIT_INIT;
              state_q    <= ST_WAIT;
            end else begin
              state_q    <= ST_CHECK;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 3'd0) state_q <= ST_CHECK;
          else                    wait_cnt_q <= wait_cnt_q - 3'd1;
        end
        ST_CHECK: begin
          if (!w_match) begin
            pass_q      <= 1'b0;
            fail_addr_q <= pc_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Shared completion path for plain instructions and matching asserts.
      if (w_complete) begin
        instr_count_q <= instr_count_q + (ADDR_W+1)'(1);
        if (w_finish) begin
          pass_q  <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end else begin
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= ST_FETCH;
        end
      end
    end
  end

  assign bus.rom_addr         = pc_q;
  assign bus.esfa_will_write  = will_write_q;
  assign bus.esfa_new_index   = w_instr.index;
  assign bus.esfa_new_value   = w_instr.value;
  assign bus.esfa_metadata    = w_instr.metadata;
  assign bus.esfa_is_metadata = w_instr.is_metadata;
  assign bus.esfa_selector    = w_instr.selector;

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_esfa_program_sequencer.sv
// ----------------------------------------------------------------------------
// tb_esfa_program_sequencer -- scoreboard bench with ROM and ESFA behavioural models. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_esfa_program_sequencer;
  import esfa_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] fail_a, fail_b;
  logic [8:0] count_a, count_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [55:0] rom_a [256];
  logic [55:0] rom_b [256];
  logic [7:0]  mem_a [256];
  logic [255:0] wr_a;
  logic        clr_a = 1'b0;
  int          cnt_b = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        snap_done, snap_pass, snap_busy;
  logic [7:0]  snap_fail, snap_addr;

  esfa_program_sequencer_if #(.ADDR_W(8)) bus_a ();
  esfa_program_sequencer_if #(.ADDR_W(8)) bus_b ();

  esfa_program_sequencer #(.ADDR_W(8), .LAST_ADDR(255), .ESFA_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .fail_addr(fail_a), .instr_count(count_a)
  );

  esfa_program_sequencer #(.ADDR_W(8), .LAST_ADDR(255), .ESFA_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .fail_addr(fail_b), .instr_count(count_b)
  );

  always #5 clk = ~clk;

  // ROMs with one cycle of read latency; ESFA model A answers one cycle after the query.
  always @(posedge clk) begin
    bus_a.rom_data <= rom_a[bus_a.rom_addr];
    bus_b.rom_data <= rom_b[bus_b.rom_addr];
    if (clr_a) wr_a <= '0;
    else if (bus_a.esfa_will_write) begin
      mem_a[bus_a.esfa_new_index] <= bus_a.esfa_new_value;
      wr_a[bus_a.esfa_new_index]  <= 1'b1;
    end
    bus_a.esfa_result_value <= mem_a[bus_a.esfa_selector];
    bus_a.esfa_result_bool  <= wr_a[bus_a.esfa_selector];
    cnt_b <= start_b ? 0 : cnt_b + 1;
  end

  // Model B only returns the right answer exactly ESFA_LAT=3 cycles after EXEC (cnt_b==2).
  assign bus_b.esfa_result_bool  = (cnt_b == 5);
  assign bus_b.esfa_result_value = (cnt_b == 5) ? 8'h5A : 8'h00;

  function automatic logic [55:0] mk(input bit wr, input logic [7:0] idx, input logic [7:0] val,
                                     input logic [7:0] meta, input bit ism, input logic [7:0] sel,
                                     input bit as, input bit halt);
    logic [55:0] w;
    w = '0;
    w[0] = wr; w[15:8] = idx; w[23:16] = val; w[31:24] = meta;
    w[32] = ism; w[47:40] = sel; w[48] = as; w[49] = halt;
    return w;
  endfunction

  task automatic prep_a();
    exp_q.delete();
    for (int i = 0; i < 256; i++) rom_a[i] = '0;
    @(negedge clk) clr_a = 1'b1;
    @(negedge clk) clr_a = 1'b0;
  endtask

  task automatic run_a(input int max_cyc, input int extra_at, output int busy_cyc, output bit tmo);
    int cyc;
    obs_q.delete();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    snap_done = done_a; snap_pass = pass_a; snap_busy = busy_a;
    snap_fail = fail_a; snap_addr = bus_a.rom_addr;
    cyc = 1; busy_cyc = 0;
    while (!done_a && cyc < max_cyc) begin
      if (busy_a) busy_cyc++;
      if (bus_a.esfa_will_write) obs_q.push_back({bus_a.esfa_new_index, bus_a.esfa_new_value});
      start_a = (cyc == extra_at);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    tmo = !done_a;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.rom_addr !== 8'd0) begin n_err++; $display("FAIL rst_rom_addr: got %h want 00", bus_a.rom_addr); end
    n_cmp++; if (bus_a.esfa_will_write !== 1'b0) begin n_err++; $display("FAIL rst_will_write: got %b want 0", bus_a.esfa_will_write); end
    n_cmp++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy_a, done_a, pass_a}); end
    n_cmp++; if (fail_a !== 8'd0) begin n_err++; $display("FAIL rst_fail_addr: got %h want 00", fail_a); end
    n_cmp++; if (count_a !== 9'd0) begin n_err++; $display("FAIL rst_instr_count: got %0d want 0", count_a); end
    n_cmp++; if ({bus_a.esfa_new_index, bus_a.esfa_new_value, bus_a.esfa_metadata, bus_a.esfa_is_metadata, bus_a.esfa_selector} !== 33'd0) begin
      n_err++; $display("FAIL rst_operands: got %h want 0", {bus_a.esfa_new_index, bus_a.esfa_new_value, bus_a.esfa_metadata, bus_a.esfa_is_metadata, bus_a.esfa_selector}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL idle_no_start_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_write_assert();
    int bc; bit tmo; logic [15:0] e;
    prep_a();
    rom_a[0] = mk(1, 8'd3, 8'h5A, 8'h00, 0, 8'd0, 0, 0);
    rom_a[1] = mk(0, 8'd0, 8'h00, 8'h5A, 1, 8'd3, 1, 1);
    exp_q.push_back({8'd3, 8'h5A});
    run_a(100, -1, bc, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL wa_timeout: got done=%b want 1", done_a); end
    n_cmp++; if (snap_busy !== 1'b1 || snap_addr !== 8'd0) begin n_err++; $display("FAIL wa_first_fetch: got busy=%b addr=%h want busy=1 addr=00", snap_busy, snap_addr); end
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL wa_write_pulses: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (obs_q[0] !== e) begin n_err++; $display("FAIL wa_write_data: got %h want %h", obs_q[0], e); end
      void'(obs_q.pop_front());
    end
    n_cmp++; if ({done_a, pass_a} !== 2'b11) begin n_err++; $display("FAIL wa_verdict: got done/pass=%b want 11", {done_a, pass_a}); end
    n_cmp++; if (count_a !== 9'd2) begin n_err++; $display("FAIL wa_instr_count: got %0d want 2", count_a); end
    n_cmp++; if (bc != 7) begin n_err++; $display("FAIL wa_busy_cycles: got %0d want 7", bc); end
  endtask

  task automatic test_fail_assert();
    int bc, chg; bit tmo; logic [15:0] e;
    prep_a();
    rom_a[0] = mk(1, 8'd5, 8'h22, 8'h00, 0, 8'd0, 0, 0);
    rom_a[1] = mk(1, 8'd6, 8'h33, 8'h00, 0, 8'd0, 0, 0);
    rom_a[2] = mk(0, 8'd0, 8'h00, 8'h11, 1, 8'd5, 1, 0);
    rom_a[3] = mk(1, 8'd7, 8'h44, 8'h00, 0, 8'd0, 0, 1);
    exp_q.push_back({8'd5, 8'h22});
    exp_q.push_back({8'd6, 8'h33});
    run_a(100, -1, bc, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL fa_timeout: got done=%b want 1", done_a); end
    n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL fa_write_pulses: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (obs_q[0] !== e) begin n_err++; $display("FAIL fa_write_data: got %h want %h", obs_q[0], e); end
      void'(obs_q.pop_front());
    end
    n_cmp++; if ({done_a, pass_a} !== 2'b10) begin n_err++; $display("FAIL fa_verdict: got done/pass=%b want 10", {done_a, pass_a}); end
    n_cmp++; if (fail_a !== 8'd2) begin n_err++; $display("FAIL fa_fail_addr: got %h want 02", fail_a); end
    n_cmp++; if (count_a !== 9'd2) begin n_err++; $display("FAIL fa_instr_count: got %0d want 2", count_a); end
    chg = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.rom_addr !== 8'd2 || bus_a.esfa_will_write !== 1'b0) chg++;
    end
    n_cmp++; if (chg != 0) begin n_err++; $display("FAIL fa_quiet_after_done: got %0d activity cycles want 0", chg); end
  endtask

  task automatic test_restart_done();
    int bc; bit tmo; logic [15:0] e;
    prep_a();
    rom_a[0] = mk(1, 8'd9, 8'h99, 8'h00, 0, 8'd0, 0, 1);
    exp_q.push_back({8'd9, 8'h99});
    run_a(100, -1, bc, tmo);
    n_cmp++; if ({snap_done, snap_pass, snap_busy} !== 3'b001) begin n_err++; $display("FAIL rd_clear_flags: got done/pass/busy=%b want 001", {snap_done, snap_pass, snap_busy}); end
    n_cmp++; if (snap_fail !== 8'd0) begin n_err++; $display("FAIL rd_clear_fail_addr: got %h want 00", snap_fail); end
    n_cmp++; if (tmo || pass_a !== 1'b1 || count_a !== 9'd1) begin n_err++; $display("FAIL rd_rerun: got done=%b pass=%b count=%0d want 1 1 1", done_a, pass_a, count_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (obs_q.size() == 0 || obs_q[0] !== e) begin n_err++; $display("FAIL rd_write_data: got %0d entries want %h", obs_q.size(), e); end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_sweep(input int extra_at);
    int bc, bad; bit tmo; logic [15:0] e;
    prep_a();
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = mk(1, 8'(i), 8'(255 - i), 8'h00, 0, 8'd0, 0, 0);
      exp_q.push_back({8'(i), 8'(255 - i)});
    end
    run_a(2000, extra_at, bc, tmo);
    n_cmp++; if (tmo || pass_a !== 1'b1) begin n_err++; $display("FAIL sw%0d_verdict: got done=%b pass=%b want 1 1", extra_at, done_a, pass_a); end
    n_cmp++; if (count_a !== 9'd256) begin n_err++; $display("FAIL sw%0d_instr_count: got %0d want 256", extra_at, count_a); end
    n_cmp++; if (bc != 768) begin n_err++; $display("FAIL sw%0d_busy_cycles: got %0d want 768", extra_at, bc); end
    n_cmp++; if (bus_a.rom_addr !== 8'd255) begin n_err++; $display("FAIL sw%0d_final_pc: got %h want ff", extra_at, bus_a.rom_addr); end
    n_cmp++; if (obs_q.size() != 256) begin n_err++; $display("FAIL sw%0d_write_pulses: got %0d want 256", extra_at, obs_q.size()); end
    bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.pop_front() !== e) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL sw%0d_write_data: got %0d wrong writes want 0", extra_at, bad); end
  endtask

  task automatic test_assert_write();
    int cyc, bc, wwc;
    for (int i = 0; i < 256; i++) rom_b[i] = '0;
    rom_b[0] = mk(1, 8'h44, 8'h77, 8'h5A, 1, 8'h44, 1, 1);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    cyc = 1; bc = 0; wwc = 0;
    while (!done_b && cyc < 50) begin
      if (busy_b) bc++;
      if (bus_b.esfa_will_write) wwc++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (done_b !== 1'b1) begin n_err++; $display("FAIL aw_timeout: got done=%b want 1", done_b); end
    n_cmp++; if (wwc != 0) begin n_err++; $display("FAIL aw_no_write: got %0d pulses want 0", wwc); end
    n_cmp++; if (pass_b !== 1'b1 || count_b !== 9'd1) begin n_err++; $display("FAIL aw_check_timing: got pass=%b count=%0d want 1 1", pass_b, count_b); end
    n_cmp++; if (bc != 6) begin n_err++; $display("FAIL aw_busy_cycles: got %0d want 6", bc); end
  endtask

  task automatic test_reset_midrun();
    int bc; bit tmo; logic [15:0] e;
    prep_a();
    for (int i = 0; i < 256; i++) rom_a[i] = mk(1, 8'(i), 8'h5C, 8'h00, 0, 8'd0, 0, 0);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus_a.rom_addr !== 8'd1 || busy_a !== 1'b1) begin n_err++; $display("FAIL rm_midrun: got addr=%h busy=%b want 01 1", bus_a.rom_addr, busy_a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus_a.rom_addr, busy_a, done_a, pass_a, fail_a, count_a} !== 28'd0) begin
      n_err++; $display("FAIL rm_async_clear: got addr=%h busy=%b done=%b pass=%b fail=%h count=%0d want all 0", bus_a.rom_addr, busy_a, done_a, pass_a, fail_a, count_a); end
    @(negedge clk);
    n_cmp++; if (bus_a.esfa_will_write !== 1'b0 || bus_a.esfa_new_index !== 8'd0) begin n_err++; $display("FAIL rm_no_strobe: got ww=%b idx=%h want 0 00", bus_a.esfa_will_write, bus_a.esfa_new_index); end
    rst_n = 1'b1;
    prep_a();
    rom_a[0] = mk(1, 8'd12, 8'hC3, 8'h00, 0, 8'd0, 0, 1);
    exp_q.push_back({8'd12, 8'hC3});
    run_a(100, -1, bc, tmo);
    n_cmp++; if (snap_addr !== 8'd0 || tmo || pass_a !== 1'b1 || count_a !== 9'd1) begin
      n_err++; $display("FAIL rm_rerun: got addr=%h done=%b pass=%b count=%0d want 00 1 1 1", snap_addr, done_a, pass_a, count_a); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (obs_q.size() == 0 || obs_q[0] !== e) begin n_err++; $display("FAIL rm_write_data: got %0d entries want %h", obs_q.size(), e); end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_write_assert();
    test_fail_assert();
    test_restart_done();
    test_sweep(-1);
    test_sweep(20);
    test_assert_write();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/esfa_program_sequencer.md
# esfa_program_sequencer

Run controller for the ESFA datapath. It fetches 56-bit instruction words from the instruction block ROM, decodes them, and drives the ESFADesign write/query ports. Assert instructions are checked against the ESFA result outputs, and the block reports a pass/fail verdict with the failing address. It replaces the free-running counter harness as the single owner of ROM addressing and ESFA sequencing.

## Interface
Parameters:
- `ADDR_W`, 8, ROM address width.
- `LAST_ADDR`, 255, highest instruction address; the run ends after this address executes.
- `ESFA_LAT`, 1, cycles from query drive to valid `esfa_result_*` (legal range 1..7).

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a run at address 0.
- `rom_addr` out ADDR_W: ROM address. Read latency is 1 cycle.
- `rom_data` in 56: instruction word.
- `esfa_will_write` out 1: ESFA write strobe.
- `esfa_new_index` out 8, `esfa_new_value` out 8, `esfa_metadata` out 8, `esfa_is_metadata` out 1, `esfa_selector` out 8: ESFA operands.
- `esfa_result_bool` in 1, `esfa_result_value` in 8: ESFA query results.
- `busy` out 1: a run is in progress.
- `done` out 1: the run has finished (sticky).
- `pass` out 1: verdict; meaningful only when `done` is 1.
- `fail_addr` out ADDR_W: address of the first failing assert.
- `instr_count` out ADDR_W+1: number of instructions completed in this run.

## Operation
Instruction fields:
- bit 0: write.
- [15:8]: index.
- [23:16]: value.
- [31:24]: metadata / expected value.
- bit 32: isMetadata / expected bool.
- [47:40]: selector.
- bit 48: assert.
- bit 49: halt.
- All other bits are reserved and ignored.

State machine: IDLE, FETCH, LOAD, EXEC, WAIT, CHECK, DONE.
- IDLE: on `start`, set pc=0, clear `instr_count`, `done`, `pass` and `fail_addr`, and go to FETCH.
- FETCH: `rom_addr`=pc; go to LOAD.
- LOAD: register `rom_data` into the instruction register (ir); go to EXEC.
- EXEC:
  - `esfa_*` operands are driven from ir. They hold stable until the next LOAD.
  - `esfa_will_write` = ir.write & ~ir.assert, for this one cycle only.
  - If the instruction is an assert, go to WAIT; otherwise the instruction completes here.
- WAIT: hold for ESFA_LAT−1 cycles (0 when ESFA_LAT=1), then go to CHECK.
- CHECK: compare `esfa_result_bool` against ir[32] and `esfa_result_value` against ir[31:24].
  - Mismatch: `pass`=0, `fail_addr`=pc, go to DONE.
  - Match: the instruction completes.

Completion of an instruction:
- `instr_count` increments.
- If ir.halt is set or pc==LAST_ADDR: `pass`=1, go to DONE.
- Otherwise pc increments and the FSM returns to FETCH.

Other rules:
- An assert with the write bit set never writes; assert takes precedence.
- A failing assert does not increment `instr_count`.
- DONE: `done`=1 and `busy`=0. A new `start` restarts the run exactly as from IDLE.
- `start` is ignored while `busy`=1.
- pc never wraps past LAST_ADDR.

## Timing
- Reset values:
  - All outputs are 0, including `rom_addr`, `esfa_will_write`, `done`, `pass`, `fail_addr` and `instr_count`.
  - State is IDLE and ir is 0.
- Reset asserted mid-run aborts immediately. No strobe is emitted after `rst_n` falls.
- `busy` rises the cycle after `start` is sampled and falls on entry to DONE.
- Per-instruction cost:
  - Non-assert: 3 cycles (FETCH, LOAD, EXEC).
  - Assert: 3 + ESFA_LAT cycles.
- The first `rom_addr`=0 is presented in the cycle after `start`.
- `done`, `pass` and `fail_addr` update together in the cycle after the deciding state.
- `start` arriving in the same cycle as the transition into DONE is ignored.

## Structure
- Shared package `esfa_seq_pkg`: instruction field bit positions, the state enum, and the 56-bit instruction width constant. The ESFA operand widths belong in the package too, shared with ESFADesign.
- One sub-module, `esfa_instr_decode`: purely combinational field extraction from ir. The FSM, pc, counters and compare logic stay in the top level.

## Test plan
- Writes then assert: addr0 write idx=3 val=0x5A; addr1 assert sel=3 expecting bool=1, val=0x5A with halt. Required: one `esfa_will_write` pulse, then `done`=1, `pass`=1, `instr_count`=2.
- Failing assert: addr2 expects val=0x11 while the ESFA returns 0x22. Required: `done`=1, `pass`=0, `fail_addr`=2, `instr_count`=2, and no further `rom_addr` changes.
- Full sweep without halt, LAST_ADDR=255: all 256 instructions non-assert. Required: `pass`=1, `instr_count`=256, 768 busy cycles, pc stops at 255.
- Assert with the write bit set, ESFA_LAT=3: `esfa_will_write` never asserts, and CHECK samples 3 cycles after EXEC.
- Reset at cycle 5 of a run: all outputs return to 0 asynchronously. A later `start` re-runs from address 0.
- `start` pulsed while `busy`: ignored. `start` pulsed in DONE: restarts and clears `done`/`pass`/`fail_addr`.
